// File: rtl/paddle_bank.sv
// paddle_bank: multi-channel vertical paddle motion with clamp/wrap limits.
// Define PADDLE_ACCEL_EN to halve the step period after ACCEL_STEPS steps.
module paddle_bank #(
  parameter int NUM_PADDLES = 2,
  parameter int Y_RES       = 600,
  parameter int PADDLE_H    = 80,
  parameter int POS_W       = 10,
  parameter int TICK_W      = 16,
  parameter int ACCEL_STEPS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         game_on,
  input  logic                         wrap_mode,
  input  logic [TICK_W-1:0]            ticks_per_px,
  input  logic [NUM_PADDLES-1:0]       up,
  input  logic [NUM_PADDLES-1:0]       down,
  output logic [NUM_PADDLES*POS_W-1:0] position,
  output logic [NUM_PADDLES-1:0]       moving_up,
  output logic [NUM_PADDLES-1:0]       moving_down,
  output logic [NUM_PADDLES-1:0]       at_limit
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOV_UP = 2'd1,
    MOV_DN = 2'd2
  } state_t;

  localparam logic [POS_W-1:0] MIN_POS = POS_W'(PADDLE_H / 2);
  localparam logic [POS_W-1:0] MAX_POS = POS_W'(Y_RES - PADDLE_H / 2);
  localparam logic [POS_W-1:0] TOP_POS = POS_W'(Y_RES - 1);
  localparam logic [POS_W-1:0] MID_POS = POS_W'(Y_RES / 2);

  logic [TICK_W-1:0] teff_norm;

  assign teff_norm = (ticks_per_px == '0) ? TICK_W'(1) : ticks_per_px;

`ifdef PADDLE_ACCEL_EN
  localparam int SW = $clog2(ACCEL_STEPS + 1);

  logic [TICK_W-1:0] half_tpp;
  logic [TICK_W-1:0] teff_fast;

  assign half_tpp  = ticks_per_px >> 1;
  assign teff_fast = (half_tpp == '0) ? TICK_W'(1) : half_tpp;
`endif

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
    state_t            state;
    state_t            nxt;
    logic [TICK_W-1:0] cnt;
    logic [TICK_W-1:0] teff;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_n;
    logic              moving;
    logic              tick_hit;
    logic              stepped;
    logic              lim;
    logic              mu;
    logic              md;

    always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
    end

    always_comb begin
      nxt = IDLE;
      unique case (1'b1)
        game_on && up[i] && !down[i]: nxt = MOV_UP;
        game_on && down[i] && !up[i]: nxt = MOV_DN;
        default:                      nxt = IDLE;
      endcase
    end

    always_comb begin
      mu = (state == MOV_UP);
      md = (state == MOV_DN);
    end

    assign moving = (state != IDLE) && (state == nxt);

`ifdef PADDLE_ACCEL_EN
    logic [SW-1:0] steps;
    logic          fast;

    assign fast = (steps == SW'(ACCEL_STEPS));
    assign teff = fast ? teff_fast : teff_norm;

    // Only real moves count; blocked or forced steps do not.
    always_ff @(posedge clk) begin
      if (!reset || !moving) steps <= '0;
      else if (stepped && !fast) steps <= steps + 1'b1;
    end
`else
    logic unused_accel;

    assign teff         = teff_norm;
    assign unused_accel = &{1'b0, stepped, (ACCEL_STEPS > 0)};
`endif

    assign tick_hit = moving && (cnt >= teff - 1'b1);

    // Out-of-range positions are pulled back before any step.
    always_comb begin
      pos_n   = pos;
      stepped = 1'b0;
      if (wrap_mode) begin
        if (pos > TOP_POS) begin
          pos_n = TOP_POS;
        end else if (tick_hit && state == MOV_UP) begin
          pos_n   = (pos == TOP_POS) ? '0 : pos + 1'b1;
          stepped = 1'b1;
        end else if (tick_hit && state == MOV_DN) begin
          pos_n   = (pos == '0) ? TOP_POS : pos - 1'b1;
          stepped = 1'b1;
        end
      end else begin
        if (pos < MIN_POS) begin
          pos_n = MIN_POS;
        end else if (pos > MAX_POS) begin
          pos_n = MAX_POS;
        end else if (tick_hit && state == MOV_UP) begin
          if (pos < MAX_POS) begin
            pos_n   = pos + 1'b1;
            stepped = 1'b1;
          end
        end else if (tick_hit && state == MOV_DN) begin
          if (pos > MIN_POS) begin
            pos_n   = pos - 1'b1;
            stepped = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        pos <= MID_POS;
        cnt <= '0;
        lim <= 1'b0;
      end else begin
        pos <= pos_n;
        lim <= !wrap_mode && (pos_n == MIN_POS || pos_n == MAX_POS);
        if (!moving || tick_hit) cnt <= '0;
        else                     cnt <= cnt + 1'b1;
      end
    end

    assign position[i*POS_W +: POS_W] = pos;
    assign moving_up[i]               = mu;
    assign moving_down[i]             = md;
    assign at_limit[i]                = lim;
  end

endmodule

// File: tb/tb_paddle_bank.sv
// tb_paddle_bank: scoreboard bench for paddle_bank (default parameters).
// Expected values are queued with a target cycle and checked after that edge.
module tb_paddle_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        game_on;
  logic        wrap_mode;
  logic [15:0] ticks_per_px;
  logic [1:0]  up;
  logic [1:0]  down;
  logic [19:0] position;
  logic [1:0]  moving_up;
  logic [1:0]  moving_down;
  logic [1:0]  at_limit;

  typedef struct {
    int    cyc;
    string tag;
    int    p0;
    int    p1;
    int    mu;
    int    md;
    int    al;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  paddle_bank dut (
    .clk         (clk),
    .reset       (reset),
    .game_on     (game_on),
    .wrap_mode   (wrap_mode),
    .ticks_per_px(ticks_per_px),
    .up          (up),
    .down        (down),
    .position    (position),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .at_limit    (at_limit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int t, input string tag, input int p0,
                          input int p1, input int mu, input int md,
                          input int al);
    exp_t e;
    e.cyc = t; e.tag = tag;
    e.p0 = p0; e.p1 = p1;
    e.mu = mu; e.md = md; e.al = al;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) chk({e.tag, ".late"}, cyc, e.cyc);
      chk({e.tag, ".pos0"}, int'(position[9:0]), e.p0);
      chk({e.tag, ".pos1"}, int'(position[19:10]), e.p1);
      chk({e.tag, ".mu"}, int'(moving_up), e.mu);
      chk({e.tag, ".md"}, int'(moving_down), e.md);
      chk({e.tag, ".al"}, int'(at_limit), e.al);
    end
  end

  initial begin
    int c;
    reset = 1'b0; game_on = 1'b0; wrap_mode = 1'b0;
    ticks_per_px = '0; up = '0; down = '0;
    repeat (3) @(negedge clk);

    c = cyc;
    push_exp(c + 1, "rst", 300, 300, 0, 0, 0);
    wait_to(c + 1);

    // game_on low: no motion
    reset = 1'b1; up = 2'b01; ticks_per_px = 16'd5;
    c = cyc;
    push_exp(c + 1, "off1", 300, 300, 0, 0, 0);
    push_exp(c + 500, "off500", 300, 300, 0, 0, 0);
    wait_to(c + 500);

    // clamp descent to MIN_POS
    game_on = 1'b1; up = 2'b00; down = 2'b01; ticks_per_px = 16'd2;
    c = cyc;
    push_exp(c + 1, "dn_ent", 300, 300, 0, 1, 0);
    push_exp(c + 3, "dn_s1", 299, 300, 0, 1, 0);
    push_exp(c + 4, "dn_h1", 299, 300, 0, 1, 0);
    push_exp(c + 5, "dn_s2", 298, 300, 0, 1, 0);
    push_exp(c + 520, "dn_41", 41, 300, 0, 1, 0);
    push_exp(c + 521, "dn_min", 40, 300, 0, 1, 1);
    push_exp(c + 600, "dn_hold", 40, 300, 0, 1, 1);
    wait_to(c + 600);

    // wrap ascent on channel 1
    wrap_mode = 1'b1; down = 2'b00; up = 2'b10; ticks_per_px = 16'd1;
    c = cyc;
    push_exp(c + 1, "wr_ent", 40, 300, 2, 0, 0);
    push_exp(c + 259, "wr_558", 40, 558, 2, 0, 0);
    push_exp(c + 300, "wr_599", 40, 599, 2, 0, 0);
    push_exp(c + 301, "wr_0", 40, 0, 2, 0, 0);
    push_exp(c + 302, "wr_1", 40, 1, 2, 0, 0);
    wait_to(c + 302);
    wrap_mode = 1'b0;
    push_exp(c + 303, "force_min", 40, 40, 2, 0, 3);
    push_exp(c + 304, "after_force", 40, 41, 2, 0, 1);
    wait_to(c + 304);
    up = 2'b00;
    push_exp(c + 305, "rel1", 40, 41, 0, 0, 1);
    wait_to(c + 305);

    // both pressed -> idle, then ticks_per_px=0
    up = 2'b01; ticks_per_px = 16'd3;
    c = cyc;
    push_exp(c + 1, "up_ent", 40, 41, 1, 0, 1);
    push_exp(c + 4, "up_s1", 41, 41, 1, 0, 0);
    push_exp(c + 7, "up_s2", 42, 41, 1, 0, 0);
    wait_to(c + 7);
    down = 2'b01;
    push_exp(c + 8, "both", 42, 41, 0, 0, 0);
    push_exp(c + 20, "both_hold", 42, 41, 0, 0, 0);
    wait_to(c + 20);
    down = 2'b00; ticks_per_px = 16'd0;
    push_exp(c + 21, "t0_ent", 42, 41, 1, 0, 0);
    push_exp(c + 22, "t0_s1", 43, 41, 1, 0, 0);
    push_exp(c + 23, "t0_s2", 44, 41, 1, 0, 0);
    push_exp(c + 30, "t0_s9", 51, 41, 1, 0, 0);
    wait_to(c + 30);

    // clamp ascent to MAX_POS on channel 1
    up = 2'b10;
    c = cyc;
    push_exp(c + 1, "mx_ent", 51, 41, 2, 0, 0);
    push_exp(c + 519, "mx_559", 51, 559, 2, 0, 0);
    push_exp(c + 520, "mx_max", 51, 560, 2, 0, 2);
    push_exp(c + 600, "mx_hold", 51, 560, 2, 0, 2);
    wait_to(c + 600);

    // reset mid-move
    reset = 1'b0;
    push_exp(c + 601, "rst_mid", 300, 300, 0, 0, 0);
    wait_to(c + 601);

    reset = 1'b1; up = 2'b00; down = 2'b01; ticks_per_px = 16'd4;
    c = cyc;
    push_exp(c + 1, "ac_ent", 300, 300, 0, 1, 0);
    push_exp(c + 5, "ac_s1", 299, 300, 0, 1, 0);
    push_exp(c + 65, "ac_s16", 284, 300, 0, 1, 0);
    push_exp(c + 66, "ac_h16", 284, 300, 0, 1, 0);
`ifdef PADDLE_ACCEL_EN
    push_exp(c + 67, "ac_s17", 283, 300, 0, 1, 0);
    push_exp(c + 69, "ac_s18", 282, 300, 0, 1, 0);
    wait_to(c + 69);
    down = 2'b00;
    push_exp(c + 70, "ac_rel", 282, 300, 0, 0, 0);
    wait_to(c + 70);
    down = 2'b01;
    push_exp(c + 71, "ac_re", 282, 300, 0, 1, 0);
    push_exp(c + 74, "ac_slow", 282, 300, 0, 1, 0);
    push_exp(c + 75, "ac_slow_s", 281, 300, 0, 1, 0);
    wait_to(c + 75);
`else
    push_exp(c + 67, "ac_h17", 284, 300, 0, 1, 0);
    push_exp(c + 69, "ac_s17", 283, 300, 0, 1, 0);
    wait_to(c + 69);
`endif

    repeat (10) begin
      if (sb.size() > 0) @(negedge clk);
    end
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/paddle_bank.md
# paddle_bank

Parametrised multi-channel paddle motion controller for the Pong datapath. It tracks NUM_PADDLES independent vertical paddles, each driven by its own up/down request. It generalises the single-paddle controller with configurable resolution, paddle height and channel count, edge clamping that accounts for paddle height, and an optional acceleration mode. Position outputs feed the renderer and collision logic directly.

## Interface
- NUM_PADDLES, 2, number of independent paddle channels
- Y_RES, 600, vertical resolution in pixels
- PADDLE_H, 80, paddle height in pixels; must be even and less than Y_RES
- POS_W, 10, width of one position field; 2^POS_W > Y_RES
- TICK_W, 16, width of ticks_per_px
- ACCEL_STEPS, 16, consecutive pixel steps before speed-up; used only with PADDLE_ACCEL_EN
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- game_on  in  1  motion enable shared by all channels
- wrap_mode  in  1  1 = positions wrap top/bottom, 0 = positions clamp
- ticks_per_px  in  TICK_W  clk cycles per 1-pixel step; 0 is treated as 1
- up  in  NUM_PADDLES  per-channel move-up request; increments position
- down  in  NUM_PADDLES  per-channel move-down request; decrements position
- position  out  NUM_PADDLES*POS_W  packed centre pixels; channel i occupies bits [i*POS_W +: POS_W]
- moving_up  out  NUM_PADDLES  channel i is in state MOV_UP
- moving_down  out  NUM_PADDLES  channel i is in state MOV_DN
- at_limit  out  NUM_PADDLES  wrap_mode=0 and position equals MIN_POS or MAX_POS

## Operation
- MIN_POS = PADDLE_H/2. MAX_POS = Y_RES - PADDLE_H/2.
- Reset (reset=0 at a clk edge): every position = Y_RES/2, state IDLE, tick counters 0, moving_up = moving_down = 0, at_limit = 0.
- Each channel has its own FSM (states IDLE, MOV_UP, MOV_DN), a TICK_W-bit tick counter and a step counter. Next state is evaluated every cycle:
  - game_on=0 → IDLE, with the position held.
  - up=1, down=0 → MOV_UP.
  - down=1, up=0 → MOV_DN.
  - up=down → IDLE.
- When the state changes, the tick counter and step counter clear.
- In MOV_UP/MOV_DN the tick counter increments each cycle. When counter ≥ Teff-1, the channel takes one 1-pixel step and the counter clears. Teff = max(ticks_per_px,1). Using ≥ makes a mid-move decrease of ticks_per_px take effect on the next cycle.
- Clamp mode (wrap_mode=0):
  - A step past MAX_POS or below MIN_POS does not happen. The state stays MOV_UP/MOV_DN.
  - If the position is outside [MIN_POS, MAX_POS], for example after leaving wrap mode, it is forced to the nearest limit on the next edge, in any state.
- Wrap mode (wrap_mode=1):
  - The position range is 0..Y_RES-1.
  - An up step from Y_RES-1 goes to 0. A down step from 0 goes to Y_RES-1.
  - A position of Y_RES or above is forced to Y_RES-1 on the next edge.
- Channels are fully independent. Simultaneous steps on different channels are all applied in the same cycle.
- Arithmetic is unsigned POS_W bits. Comparisons must be written so the decrement at 0 never underflows.

## Timing
- Inputs are sampled on the rising edge of clk. The state and moving_* flags update 1 cycle after a request changes.
- The first pixel step lands Teff edges after the state enters MOV_UP/MOV_DN, which is Teff+1 edges after the request is sampled.
- After that, one step every Teff cycles while the request is held.
- Reset asserted mid-move overrides everything at that edge.
- at_limit is registered with the position. It updates in the same cycle the position reaches or leaves a limit.

## Configuration
- PADDLE_ACCEL_EN defined:
  - After ACCEL_STEPS consecutive steps in the same direction, Teff becomes max(ticks_per_px>>1, 1) for that channel.
  - The speed-up ends when the state changes or game_on=0, and Teff returns to normal.
  - A blocked clamp step does not count toward ACCEL_STEPS.
- PADDLE_ACCEL_EN undefined:
  - The step counter and accel logic are absent. Teff is always max(ticks_per_px,1), and ACCEL_STEPS is ignored.

## Test plan
- Reset with defaults → both positions = 300, all flags 0, at_limit = 0.
- game_on=0, up[0]=1 for 500 cycles, ticks_per_px=5 → position[0] stays 300 and moving_up[0]=0.
- game_on=1, wrap_mode=0, down[0]=1, ticks_per_px=2 → position[0] decrements every 2 cycles to 40, then holds; at_limit[0]=1; moving_down[0] stays 1; channel 1 stays at 300.
- wrap_mode=1, up[1]=1, ticks_per_px=1 from 558 → after 42 steps position[1]=0, next step 1.
- up[0]=down[0]=1 → IDLE within 1 cycle and position frozen. Then ticks_per_px=0 with up[0]=1 → one step per cycle.
- With PADDLE_ACCEL_EN, ticks_per_px=4, down held → 16 steps at period 4, then period 2. Releasing and pressing again restores period 4.
